// File: rtl/ni_packetizer.sv
// ni_packetizer: network-interface injection stage feeding a router LOCAL port.
// Takes a packet descriptor plus payload words, emits HEAD/BODY/TAIL/HEADTAIL flits
// with the whole packet locked to one VC, under per-VC credit flow control.
// Optional build macro NI_PKTZ_STATS_EN adds packet/flit counters (pkt_cnt_o, flit_cnt_o).
// Flit layout (noc_params::flit_t):
//   head : {label[63:62], x_dest[61:60], y_dest[59:58], head_pl[57:0]}
//   body : {label[63:62], bt_pl[61:0]}
// Labels: HEAD=0, BODY=1, TAIL=2, HEADTAIL=3.
module ni_packetizer #(
    parameter int unsigned MAX_PKT_FLITS = 16,
    parameter int unsigned LEN_W = $clog2(MAX_PKT_FLITS + 1),
    localparam int unsigned VC_NUM = 2,
    localparam int unsigned VC_SIZE = 1,
    localparam int unsigned VC_DEPTH = 4,
    localparam int unsigned FLIT_WIDTH = 64,
    localparam int unsigned DEST_ADDR_SIZE_X = 2,
    localparam int unsigned DEST_ADDR_SIZE_Y = 2,
    localparam int unsigned BODY_PAYLOAD_SIZE = 62
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        msg_valid_i,
    output logic                        msg_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] msg_x_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] msg_y_i,
    input  logic [LEN_W-1:0]            msg_len_i,
    input  logic                        data_valid_i,
    output logic                        data_ready_o,
    input  logic [BODY_PAYLOAD_SIZE-1:0] data_i,
    output logic [FLIT_WIDTH-1:0]       flit_o,
    output logic                        flit_valid_o,
    output logic [VC_SIZE-1:0]          vc_o,
    input  logic [VC_NUM-1:0]           credit_i,
    output logic                        credit_err_o
`ifdef NI_PKTZ_STATS_EN
    ,
    output logic [31:0]                 pkt_cnt_o,
    output logic [31:0]                 flit_cnt_o
`endif
);

    localparam int unsigned CRED_W = $clog2(VC_DEPTH + 1);
    localparam int unsigned HEAD_PL_W = 58;

    localparam logic [1:0] LblHead     = 2'd0;
    localparam logic [1:0] LblBody     = 2'd1;
    localparam logic [1:0] LblTail     = 2'd2;
    localparam logic [1:0] LblHeadTail = 2'd3;

    typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

    state_e                      state_q, state_d;
    logic [DEST_ADDR_SIZE_X-1:0] x_q;
    logic [DEST_ADDR_SIZE_Y-1:0] y_q;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            rem_q;
    logic [VC_SIZE-1:0]          vc_lock_q;
    logic [VC_SIZE-1:0]          rr_q;
    logic [CRED_W-1:0]           credit_q [VC_NUM];
    logic [CRED_W-1:0]           credit_d [VC_NUM];
    logic                        credit_err_q, err_set;
    logic [FLIT_WIDTH-1:0]       flit_q, flit_d;
    logic                        flit_valid_q;
    logic [VC_SIZE-1:0]          vc_q;

    logic                        any_credit;
    logic [VC_SIZE-1:0]          pick_vc;
    logic [VC_SIZE-1:0]          rr_next;
    logic [VC_SIZE-1:0]          send_vc;
    logic                        send;
    logic [LEN_W-1:0]            msg_len_eff;

    assign msg_len_eff = (msg_len_i == '0) ? LEN_W'(1) : msg_len_i;
    assign send        = data_valid_i & data_ready_o;
    assign send_vc     = (state_q == StHead) ? pick_vc : vc_lock_q;
    assign rr_next     = (pick_vc == VC_SIZE'(VC_NUM - 1)) ? '0 : pick_vc + 1'b1;

    // Round-robin VC pick: first VC with credit, starting at the rr pointer.
    always_comb begin
        any_credit = 1'b0;
        pick_vc    = '0;
        for (int unsigned i = 0; i < VC_NUM; i++) begin
            int unsigned idx;
            idx = (int'(rr_q) + i) % VC_NUM;
            if (!any_credit && credit_q[idx] != '0) begin
                any_credit = 1'b1;
                pick_vc    = VC_SIZE'(idx);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (msg_valid_i) state_d = StHead;
            StHead: if (send) state_d = (len_q == LEN_W'(1)) ? StIdle : StBody;
            StBody: if (send && rem_q == LEN_W'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: handshake readiness per state.
    always_comb begin
        msg_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        unique case (state_q)
            StIdle: msg_ready_o = 1'b1;
            StHead: data_ready_o = any_credit;
            StBody: data_ready_o = (credit_q[vc_lock_q] != '0);
            default: ;
        endcase
    end

    // Flit assembly for the word being handed over this cycle.
    always_comb begin
        if (state_q == StHead) begin
            flit_d = {(len_q == LEN_W'(1)) ? LblHeadTail : LblHead, x_q, y_q,
                      data_i[HEAD_PL_W-1:0]};
        end else begin
            flit_d = {(rem_q == LEN_W'(1)) ? LblTail : LblBody, data_i};
        end
    end

    // Credit counters: send decrements, credit_i increments, both cancel out.
    always_comb begin
        err_set = 1'b0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            logic dec, inc;
            dec         = send && (send_vc == VC_SIZE'(v));
            inc         = credit_i[v];
            credit_d[v] = credit_q[v];
            if (inc && !dec) begin
                // Saturate on an over-return and flag it.
                if (credit_q[v] == CRED_W'(VC_DEPTH)) err_set = 1'b1;
                else credit_d[v] = credit_q[v] + 1'b1;
            end else if (dec && !inc) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end

    // Credit state and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < VC_NUM; v++) credit_q[v] <= CRED_W'(VC_DEPTH);
            credit_err_q <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < VC_NUM; v++) credit_q[v] <= credit_d[v];
            if (err_set) credit_err_q <= 1'b1;
        end
    end

    // Packet context: descriptor latch, remaining count, VC lock, rr pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            vc_lock_q <= '0;
            rr_q      <= '0;
        end else begin
            if (state_q == StIdle && msg_valid_i) begin
                x_q   <= msg_x_i;
                y_q   <= msg_y_i;
                len_q <= msg_len_eff;
                rem_q <= msg_len_eff;
            end
            if (state_q == StHead && send) begin
                vc_lock_q <= pick_vc;
                rr_q      <= rr_next;
                rem_q     <= len_q - LEN_W'(1);
            end
            if (state_q == StBody && send) rem_q <= rem_q - LEN_W'(1);
        end
    end

    // Registered flit output; flit_o holds between sends.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            vc_q         <= '0;
        end else begin
            flit_valid_q <= send;
            if (send) begin
                flit_q <= flit_d;
                vc_q   <= send_vc;
            end
        end
    end

    assign flit_o       = flit_q;
    assign flit_valid_o = flit_valid_q;
    assign vc_o         = vc_q;
    assign credit_err_o = credit_err_q;

`ifdef NI_PKTZ_STATS_EN
    logic [31:0] pkt_cnt_q, flit_cnt_q;

    // Statistics, counted on flits as they appear at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else if (flit_valid_q) begin
            flit_cnt_q <= flit_cnt_q + 32'd1;
            if (flit_q[FLIT_WIDTH-1 -: 2] == LblTail || flit_q[FLIT_WIDTH-1 -: 2] == LblHeadTail)
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign flit_cnt_o = flit_cnt_q;
`endif

endmodule
